// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: state type and default constants for the DDS front-panel controller
package dds_ctrl_pkg;
   typedef enum logic {MANUAL, SWEEP} state_t;
   localparam logic [15:0] FINIT      = 16'h0080;
   localparam logic [15:0] FMIN       = 16'h0010;
   localparam logic [15:0] FMAX       = 16'h0800;
   localparam logic [15:0] FSTEP_MAN  = 16'h0040;
   localparam logic [15:0] SWEEP_STEP = 16'h0004;
   localparam int NUM_MODES = 5;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes an active-low raw key, debounces it and emits a one-cycle press pulse
module key_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic press
);
   localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic [1:0] sync;
   logic stable, stable_d;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync     <= 2'b11;
         stable   <= 1'b1;
         stable_d <= 1'b1;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync     <= {sync[0], key};
         stable_d <= stable;
         press    <= stable_d & ~stable;
         // any disagreement that does not persist restarts the count
         if (sync[1] == stable) cnt <= '0;
         else if (cnt == CW'(DEB_CYCLES - 1)) begin
            stable <= sync[1];
            cnt    <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/dds_ctrl.sv
// dds_ctrl: pushbutton front panel producing the DDS waveform select and tuning word,
// with manual stepping and an automatic linear sweep
module dds_ctrl import dds_ctrl_pkg::*; #(
   parameter int N                   = 16,
   parameter int DEB_CYCLES          = 500000,
   parameter logic [N-1:0] FINIT      = dds_ctrl_pkg::FINIT,
   parameter logic [N-1:0] FMIN       = dds_ctrl_pkg::FMIN,
   parameter logic [N-1:0] FMAX       = dds_ctrl_pkg::FMAX,
   parameter logic [N-1:0] FSTEP_MAN  = dds_ctrl_pkg::FSTEP_MAN,
   parameter logic [N-1:0] SWEEP_STEP = dds_ctrl_pkg::SWEEP_STEP,
   parameter int SWEEP_DIV           = 50000,
   parameter int NUM_MODES           = dds_ctrl_pkg::NUM_MODES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_mode,
   input  logic         key_freq,
   input  logic         key_sweep,
   output logic [2:0]   choose,
   output logic [N-1:0] fword,
   output logic         fword_upd,
   output logic         sweeping
);
   localparam int TW = SWEEP_DIV > 1 ? $clog2(SWEEP_DIV) : 1;
   logic press_mode, press_freq, press_sweep;
   state_t state, state_n;
   logic [N-1:0] fword_n;
   logic [TW-1:0] tick, tick_n;
   logic upd_n, sweeping_n, tick_end;
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode  (.clk(clk), .reset(reset), .key(key_mode),  .press(press_mode));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_freq  (.clk(clk), .reset(reset), .key(key_freq),  .press(press_freq));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sweep (.clk(clk), .reset(reset), .key(key_sweep), .press(press_sweep));
   // the extra carry bit keeps a step past the top of the range from aliasing low
   function automatic logic [N-1:0] step_wrap(input logic [N-1:0] f, input logic [N-1:0] inc);
      logic [N:0] nx;
      nx = {1'b0, f} + {1'b0, inc};
      return nx > {1'b0, FMAX} ? FMIN : nx[N-1:0];
   endfunction
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= MANUAL;
         fword     <= FINIT;
         fword_upd <= 1'b0;
         sweeping  <= 1'b0;
         tick      <= '0;
         choose    <= '0;
      end else begin
         state     <= state_n;
         fword     <= fword_n;
         fword_upd <= upd_n;
         sweeping  <= sweeping_n;
         tick      <= tick_n;
         choose    <= press_mode ? (choose == 3'(NUM_MODES - 1) ? 3'd0 : choose + 3'd1) : choose;
      end
   end
   always_comb begin
      state_n = press_sweep ? (state == MANUAL ? SWEEP : MANUAL) : state;
   end
   // a sweep key press always wins over a coincident step
   always_comb begin
      tick_end   = state == SWEEP && tick == TW'(SWEEP_DIV - 1);
      fword_n    = press_sweep ? (state == MANUAL ? FMIN : fword)
                 : state == SWEEP ? (tick_end ? step_wrap(fword, SWEEP_STEP) : fword)
                 : press_freq ? step_wrap(fword, FSTEP_MAN) : fword;
      upd_n      = press_sweep ? state == MANUAL : state == SWEEP ? tick_end : press_freq;
      tick_n     = state == SWEEP && !press_sweep && !tick_end ? tick + 1'b1 : '0;
      sweeping_n = state_n == SWEEP;
   end
endmodule
